// File: rtl/div_16_seq.sv
// div_16_seq: sequential signed Q2.13 divider, q = (a * 2^13) / b.
// Restoring division, one quotient bit per cycle. The magnitude is truncated
// toward zero, and a quotient that does not fit 16 bits is saturated. A zero
// divisor gives a signed full-scale result and raises dz.
//
// Handshake: start is only sampled while busy=0. An accepted start is followed
// by busy=1 for 30 cycles. Then done pulses for one cycle, with q/ovf/dz
// updated on that same edge and busy already low. A start presented during the
// done cycle is therefore accepted on the next edge.
module div_16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] q,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        dz,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    // dvd first holds |a| << 13. Quotient bits are shifted in at the bottom,
    // so after 29 steps it holds the 29-bit quotient magnitude.
    logic [28:0] dvd;
    logic [15:0] dvs;
    logic [16:0] rem;
    logic [4:0]  cnt;
    logic        neg;
    logic        a_neg;
    logic        b_zero;

    logic [15:0] abs_a;
    logic [15:0] abs_b;
    logic [16:0] rem_sh;
    logic        ge;
    logic [16:0] rem_nx;
    logic [15:0] q_fin;
    logic        ovf_fin;
    logic        dz_fin;

    // Operand magnitudes. |-32768| = 0x8000 still fits as an unsigned 16-bit value.
    always_comb begin
        abs_a = a[15] ? (~a + 16'd1) : a;
        abs_b = b[15] ? (~b + 16'd1) : b;
    end

    // One restoring step: shift the next dividend bit in, then subtract if it fits.
    always_comb begin
        rem_sh = {rem[15:0], dvd[28]};
        ge     = rem[16] | (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
    end

    // Final result: divide-by-zero first, then saturation, then sign restore.
    always_comb begin
        q_fin   = 16'h0000;
        ovf_fin = 1'b0;
        dz_fin  = 1'b0;
        if (b_zero) begin
            q_fin  = a_neg ? 16'h8000 : 16'h7FFF;
            dz_fin = 1'b1;
        end else if (!neg && (dvd > 29'h0000_7FFF)) begin
            q_fin   = 16'h7FFF;
            ovf_fin = 1'b1;
        end else if (neg && (dvd > 29'h0000_8000)) begin
            q_fin   = 16'h8000;
            ovf_fin = 1'b1;
        end else begin
            q_fin = neg ? (~dvd[15:0] + 16'd1) : dvd[15:0];
        end
    end

    // Next-state logic. The sequence always runs 29 steps, whatever the operands.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == 5'd0) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register. Reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Datapath: capture on accepted start, iterate in CALC, publish in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            a_neg  <= 1'b0;
            b_zero <= 1'b0;
            q      <= 16'h0000;
            ovf    <= 1'b0;
            dz     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg    <= a[15] ^ b[15];
                        a_neg  <= a[15];
                        b_zero <= (b == 16'h0000);
                        dvd    <= {abs_a, 13'd0};
                        dvs    <= abs_b;
                        rem    <= '0;
                        cnt    <= 5'd28;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= {dvd[27:0], ge};
                    cnt <= cnt - 5'd1;
                end
                FIN: begin
                    q    <= q_fin;
                    ovf  <= ovf_fin;
                    dz   <= dz_fin;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // busy covers CALC and FIN, so it is already low in the done cycle.
    always_comb begin
        busy      = (state != IDLE);
        dbg_state = state;
    end

endmodule
